// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter slice.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } dmem_state_e;

   localparam int unsigned STACK_BASE_DEF = 128;
   localparam int unsigned STACK_END_DEF  = 223;

   // Offset into the stack window; a single wrap keeps the window circular.
   function automatic logic [7:0] stack_map(
      input logic [7:0]  offset,
      input int unsigned base = STACK_BASE_DEF,
      input int unsigned lim  = STACK_END_DEF
   );
      logic [8:0] s;
      s = {1'b0, offset} + 9'(base);
      if (s >= 9'(lim))
         s = s - 9'(lim - base);
      return s[7:0];
   endfunction

endpackage

// File: rtl/dmem_rr_fsm.sv
// Round-robin ownership FSM with burst locking and bounded lock length.
module dmem_rr_fsm
   import dmem_pkg::*;
#(
   parameter int unsigned MAX_LOCK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic lock0,
   input  logic lock1,
   output logic gnt0,
   output logic gnt1
);

   localparam int unsigned CW = $clog2(MAX_LOCK) + 1;
   localparam logic [CW:0] MAX_LOCK_W = (CW + 1)'(MAX_LOCK);

   dmem_state_e   state, state_nx;
   logic          rr_last, rr_last_nx;
   logic [CW-1:0] lock_cnt, lock_cnt_nx;
   logic          own_id, own_req, own_lock, oth_req, lock_room;

   assign gnt0      = (state == OWN0);
   assign gnt1      = (state == OWN1);
   assign own_id    = (state == OWN1);
   assign own_req   = own_id ? req1  : req0;
   assign own_lock  = own_id ? lock1 : lock0;
   assign oth_req   = own_id ? req0  : req1;
   assign lock_room = (({1'b0, lock_cnt} + 1'b1) < MAX_LOCK_W);

   always_comb begin
      state_nx    = state;
      rr_last_nx  = rr_last;
      lock_cnt_nx = lock_cnt;
      case (state)
         IDLE: begin
            if (req0 && req1)
               state_nx = rr_last ? OWN0 : OWN1;
            else if (req0)
               state_nx = OWN0;
            else if (req1)
               state_nx = OWN1;
         end
         OWN0, OWN1: begin
            if (own_req && own_lock && lock_room) begin
               lock_cnt_nx = lock_cnt + 1'b1;
            end else if (own_req || !own_lock) begin
               // Release; only an accepted beat counts as having been served.
               lock_cnt_nx = '0;
               if (own_req)
                  rr_last_nx = own_id;
               if (oth_req)
                  state_nx = own_id ? OWN0 : OWN1;
               else if (!own_req)
                  state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         rr_last  <= 1'b1;
         lock_cnt <= '0;
      end else begin
         state    <= state_nx;
         rr_last  <= rr_last_nx;
         lock_cnt <= lock_cnt_nx;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM; port 1 is stack-windowed.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned MAX_LOCK   = 4,
   parameter int unsigned STACK_BASE = STACK_BASE_DEF,
   parameter int unsigned STACK_END  = STACK_END_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic       lock0,
   input  logic       lock1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       rvalid0,
   output logic       rvalid1,
   output logic [7:0] rdata,
   output logic       mem_en,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata
);

   logic       acc0, acc1;
   logic [7:0] addr1_phys;

   dmem_rr_fsm #(
      .MAX_LOCK(MAX_LOCK)
   ) u_fsm (
      .clk   (clk),
      .rst   (rst),
      .req0  (req0),
      .req1  (req1),
      .lock0 (lock0),
      .lock1 (lock1),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

   assign acc0       = gnt0 & req0;
   assign acc1       = gnt1 & req1;
   assign addr1_phys = stack_map(addr1, STACK_BASE, STACK_END);
   assign rdata      = mem_rdata;

   always_comb begin
      mem_en    = acc0 | acc1;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (acc0) begin
         mem_we    = we0;
         mem_addr  = addr0;
         mem_wdata = wdata0;
      end else if (acc1) begin
         mem_we    = we1;
         mem_addr  = addr1_phys;
         mem_wdata = wdata1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= acc0 & ~we0;
         rvalid1 <= acc1 & ~we1;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against an ownership-level model.
module tb_dmem_arbiter;

   localparam int MAXL = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic       lock0 = 1'b0, lock1 = 1'b0;
   logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic       gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
   logic [7:0] rdata, mem_addr, mem_wdata;
   logic [7:0] mem_rdata = '0;

   logic [7:0] ram     [256];
   logic [7:0] ref_mem [256];

   int total = 0;
   int bad   = 0;

   dmem_arbiter #(
      .MAX_LOCK   (MAXL),
      .STACK_BASE (128),
      .STACK_END  (223)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .lock0     (lock0),
      .lock1     (lock1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM seen by the DUT.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we)
            ram[mem_addr] <= mem_wdata;
         else
            mem_rdata <= ram[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int phys1(input int off);
      int s;
      s = off + 128;
      if (s >= 223)
         s = s - 95;
      return s % 256;
   endfunction

   // Reference model: who owns the RAM, who was served last, beats taken under lock.
   int         m_own  = -1;
   int         m_last = 1;
   int         m_lk   = 0;
   bit         m_pv0  = 1'b0, m_pv1 = 1'b0;
   logic [7:0] m_pd   = '0;

   always @(negedge clk) begin
      int         acc, a, o;
      logic       w, r, l, oth;
      logic [7:0] d;
      if (!rst) begin
         m_own = -1; m_last = 1; m_lk = 0; m_pv0 = 1'b0; m_pv1 = 1'b0;
         chk("rst_gnt0", gnt0, 0);
         chk("rst_gnt1", gnt1, 0);
         chk("rst_rvalid0", rvalid0, 0);
         chk("rst_rvalid1", rvalid1, 0);
         chk("rst_mem_en", mem_en, 0);
         chk("rst_mem_we", mem_we, 0);
      end else begin
         chk("gnt0", gnt0, m_own == 0);
         chk("gnt1", gnt1, m_own == 1);
         if (m_own == 0 && req0)      acc = 0;
         else if (m_own == 1 && req1) acc = 1;
         else                         acc = -1;
         chk("mem_en", mem_en, acc >= 0);
         chk("rvalid0", rvalid0, m_pv0);
         chk("rvalid1", rvalid1, m_pv1);
         if (m_pv0 || m_pv1)
            chk("rdata", rdata, m_pd);
         m_pv0 = 1'b0;
         m_pv1 = 1'b0;
         if (acc >= 0) begin
            a = (acc == 1) ? phys1(int'(addr1)) : int'(addr0);
            w = (acc == 1) ? we1 : we0;
            d = (acc == 1) ? wdata1 : wdata0;
            chk("mem_we", mem_we, w);
            chk("mem_addr", mem_addr, a);
            if (w) begin
               chk("mem_wdata", mem_wdata, d);
               ref_mem[a] = d;
            end else begin
               m_pd = ref_mem[a];
               if (acc == 1) m_pv1 = 1'b1;
               else          m_pv0 = 1'b1;
            end
         end
         if (m_own < 0) begin
            if (req0 && req1) m_own = (m_last == 1) ? 0 : 1;
            else if (req0)    m_own = 0;
            else if (req1)    m_own = 1;
         end else begin
            o   = m_own;
            r   = (o == 1) ? req1  : req0;
            l   = (o == 1) ? lock1 : lock0;
            oth = (o == 1) ? req0  : req1;
            if (r && l && (m_lk + 1 < MAXL)) begin
               m_lk = m_lk + 1;
            end else if (r) begin
               m_last = o;
               m_lk   = 0;
               m_own  = oth ? 1 - o : o;
            end else if (!l) begin
               m_lk  = 0;
               m_own = oth ? 1 - o : -1;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int p, output int waitc);
      waitc = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if ((p == 0 && gnt0) || (p == 1 && gnt1)) begin
            waitc = n;
            break;
         end
      end
      if (waitc < 0)
         chk("gnt_timeout", 0, 1);
   endtask

   task automatic beat(input int p, input logic w, input logic [7:0] a, input logic [7:0] d,
                       output int waitc, output logic [7:0] seen);
      if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
      wait_gnt(p, waitc);
      seen = mem_addr;
      idle(1);
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         wc, beats;
      logic [7:0] sa;
      logic       a0, a1;
      int         offs [4] = '{0, 94, 95, 100};
      int         exps [4] = '{128, 222, 128, 133};

      for (int i = 0; i < 256; i++) begin
         ram[i]     = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      idle(3);
      rst = 1'b1;
      idle(1);

      // Continuous requests from both ports, no lock.
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h05; wdata1 = 8'h5A;
      @(negedge clk);
      chk("alt_idle", {gnt0, gnt1}, 2'b00);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("alt_g0", gnt0, (i % 2) == 0);
         chk("alt_g1", gnt1, (i % 2) == 1);
         chk("alt_en", mem_en, 1);
      end
      idle(1);
      req0 = 1'b0; req1 = 1'b0;
      idle(3);

      // Port 0 single read.
      beat(0, 1'b0, 8'h40, 8'h00, wc, sa);
      chk("rd40_lat", wc, 1);
      chk("rd40_addr", sa, 8'h40);
      chk("rd40_rv", rvalid0, 1);
      chk("rd40_data", rdata, ref_mem[8'h40]);
      idle(2);

      // Port 1 writes through the stack window.
      for (int i = 0; i < 4; i++) begin
         beat(1, 1'b1, 8'(offs[i]), 8'($urandom), wc, sa);
         chk("map", sa, exps[i]);
         chk("wr_rv1", rvalid1, 0);
      end
      idle(3);

      // Locked port-1 burst with port 0 pending.
      req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1; addr1 = 8'd3; wdata1 = 8'h77;
      idle(1);
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h22;
      beats = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (gnt0) break;
         if (gnt1 && req1) beats++;
      end
      chk("lock_beats", beats, 4);
      chk("lock_hand", gnt0, 1);
      idle(1);
      req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
      idle(3);

      // Reset in the middle of a locked read burst.
      req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 8'd7;
      wait_gnt(1, wc);
      idle(1);
      chk("pre_rst_rv1", rvalid1, 1);
      chk("pre_rst_g1", gnt1, 1);
      #1 rst = 1'b0;
      #1;
      chk("rst_async_g1", gnt1, 0);
      chk("rst_async_rv1", rvalid1, 0);
      chk("rst_async_en", mem_en, 0);
      req1 = 1'b0; lock1 = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(1);
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("tie_g0", gnt0, 1);
      chk("tie_g1", gnt1, 0);
      idle(1);
      req0 = 1'b0;
      @(negedge clk);
      chk("tie_next_g1", gnt1, 1);
      idle(1);
      req1 = 1'b0;
      idle(3);

      // Random traffic; requests held until accepted.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         a0 = gnt0 && req0;
         a1 = gnt1 && req1;
         @(posedge clk);
         #1;
         if (c == 1500) rst = 1'b0;
         if (c == 1503) rst = 1'b1;
         if (!req0 || a0) begin
            req0   = ($urandom % 4) != 0;
            we0    = 1'($urandom % 2);
            addr0  = 8'($urandom);
            wdata0 = 8'($urandom);
         end
         if (!req1 || a1) begin
            req1   = ($urandom % 4) != 0;
            we1    = 1'($urandom % 2);
            addr1  = 8'($urandom);
            wdata1 = 8'($urandom);
         end
         lock0 = ($urandom % 3) == 0;
         lock1 = ($urandom % 3) == 0;
      end
      req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
